mul_div_unit: RTL and testbench

//   Iterative multi-cycle multiply/divide engine directly upstream of the HI/LO register pair.
//   - Takes MULT/MULTU/DIV/DIVU operands from the EX stage.
//   - Computes one bit per cycle.
//   - Presents the 64-bit {HI,LO} result with a one-cycle done/write pulse for HI/LO to capture.
//   - busy is used by hazard logic to stall MFHI/MFLO and a new mul/div issue.

---
 rtl/mul_div_if.sv | 25 ++
 rtl/mul_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mul_div_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// mul_div_if: EX-stage issue bus and HI/LO result bus of the multiply/divide unit.
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic [1:0]           op;
  logic                 flush;
  logic [WIDTH-1:0]     opA;
  logic [WIDTH-1:0]     opB;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  // Pipeline side: issues operations and consumes results.
  modport master (
    output start, op, flush, opA, opB,
    input  busy, done, result
  );

  // Engine side.
  modport slave (
    input  start, op, flush, opA, opB,
    output busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU engine feeding HI/LO.
// Optional feature macro: MULDIV_DIV_EN builds the restoring divider; without it
// DIV/DIVU complete one cycle after issue with a zero result.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  mul_div_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [RW-1:0]    result_q;
  logic [RW-1:0]    acc_q;
  logic [RW-1:0]    acc_d;
  logic [RW-1:0]    fix_d;
  logic [WIDTH-1:0] opnd_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_lo_q;

  logic             signed_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH:0]   sum_c;

`ifdef MULDIV_DIV_EN
  logic             is_div_q;
  logic             neg_hi_q;
  logic [WIDTH-1:0] a_raw_q;
  logic [WIDTH:0]   shifted_c;
  logic             ge_c;
  logic [WIDTH-1:0] quo_c;
  logic [WIDTH-1:0] rem_c;
`endif

  // Operand magnitudes and sign flags; the magnitude of the most-negative value fits unsigned.
  always_comb begin
    signed_c = ~bus.op[0];
    a_neg_c  = signed_c & bus.opA[WIDTH-1];
    b_neg_c  = signed_c & bus.opB[WIDTH-1];
    a_mag_c  = a_neg_c ? -bus.opA : bus.opA;
    b_mag_c  = b_neg_c ? -bus.opB : bus.opB;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    sum_c = {1'b0, acc_q[RW-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    acc_d = {sum_c, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    shifted_c = acc_q[RW-1:WIDTH-1];
    ge_c      = shifted_c >= {1'b0, opnd_q};
    if (is_div_q) begin
      if (ge_c) begin
        acc_d = {WIDTH'(shifted_c - {1'b0, opnd_q}), acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[RW-2:0], 1'b0};
      end
    end
`endif
  end

  // Sign fix-up applied to the final iteration's value on the way into result.
  always_comb begin
    fix_d = neg_lo_q ? -acc_d : acc_d;
`ifdef MULDIV_DIV_EN
    quo_c = acc_d[WIDTH-1:0];
    rem_c = acc_d[RW-1:WIDTH];
    if (is_div_q) begin
      if (opnd_q == {WIDTH{1'b0}}) begin
        fix_d = {a_raw_q, {WIDTH{1'b1}}};
      end else begin
        fix_d = {(neg_hi_q ? -rem_c : rem_c), (neg_lo_q ? -quo_c : quo_c)};
      end
    end
`endif
  end

  // Control FSM and datapath registers; flush wins over everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      a_raw_q  <= '0;
`endif
    end else if (bus.flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q   <= 1'b1;
            neg_lo_q <= a_neg_c ^ b_neg_c;
            cnt_q    <= CW'(WIDTH - 1);
`ifdef MULDIV_DIV_EN
            is_div_q <= bus.op[1];
            neg_hi_q <= a_neg_c;
            a_raw_q  <= bus.opA;
            acc_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag_c : b_mag_c)};
            opnd_q   <= bus.op[1] ? b_mag_c : a_mag_c;
            state_q  <= S_CALC;
`else
            if (bus.op[1]) begin
              result_q <= '0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, b_mag_c};
              opnd_q  <= a_mag_c;
              state_q <= S_CALC;
            end
`endif
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            result_q <= fix_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed table, corner sequences and random ops against a reference model.
module tb_mul_div_unit;
  localparam int unsigned W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [63:0] last_exp = 64'd0;

  mul_div_if #(.WIDTH(W)) bus ();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    q  = 0;
    r  = 0;
    if (op == 2'b00) return 64'(sa * sb);
    if (op == 2'b01) return ua * ub;
    if (!DIV_ON) return 64'd0;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (op == 2'b10) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {32'(ua % ub), 32'(ua / ub)};
  endfunction

  function automatic int ref_lat(input logic [1:0] op);
    return (op[1] && !DIV_ON) ? 1 : 33;
  endfunction

  // Issue one op at a negedge, scramble operands after acceptance, check latency/result/busy.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    int got_lat;
    bit busy_ok;
    got_lat   = -1;
    busy_ok   = 1'b1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.opA   = $urandom;
    bus.opB   = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    check({name, " latency"}, 64'(got_lat), 64'(lat));
    check({name, " result"}, bus.result, exp);
    check({name, " busy held"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    check({name, " idle after"}, {62'd0, bus.busy, bus.done}, 64'd0);
    last_exp = exp;
  endtask

  // Watch n cycles and report whether done ever pulsed.
  task automatic watch_done(input int n, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  vec_t vecs[$];
  bit   seen;
  int   got_lat;

  initial begin
    vecs.push_back('{"multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{"mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{"mult minneg", 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000});
    vecs.push_back('{"mult -1*-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001});
    vecs.push_back('{"mult 4*5", 2'b00, 32'd4, 32'd5, 64'd20});
    vecs.push_back('{"multu zero", 2'b01, 32'd0, 32'h1234_5678, 64'd0});
    vecs.push_back('{"div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2,
                     DIV_ON ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0});
    vecs.push_back('{"divu 7/0", 2'b11, 32'd7, 32'd0, DIV_ON ? 64'h0000_0007_FFFF_FFFF : 64'd0});
    vecs.push_back('{"div 9/3", 2'b10, 32'd9, 32'd3, DIV_ON ? 64'h0000_0000_0000_0003 : 64'd0});
    vecs.push_back('{"div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE,
                     DIV_ON ? 64'h0000_0001_FFFF_FFFD : 64'd0});
    vecs.push_back('{"div minneg/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                     DIV_ON ? 64'h0000_0000_8000_0000 : 64'd0});
    vecs.push_back('{"div -7/0", 2'b10, 32'hFFFF_FFF9, 32'd0,
                     DIV_ON ? 64'hFFFF_FFF9_FFFF_FFFF : 64'd0});
    vecs.push_back('{"divu 100/7", 2'b11, 32'd100, 32'd7, DIV_ON ? 64'h0000_0002_0000_000E : 64'd0});

    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'b00;
    bus.opA   = '0;
    bus.opB   = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    check("reset result", bus.result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back to back (each start lands in the first IDLE cycle).
    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, ref_lat(vecs[i].op));
    end

    // start re-asserted while busy is ignored.
    bus.start = 1'b1; bus.op = 2'b01; bus.opA = 32'd2; bus.opB = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    got_lat   = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 10) begin
        bus.start = 1'b1; bus.op = 2'b01; bus.opA = 32'd5; bus.opB = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        got_lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    check("restart latency", 64'(got_lat), 64'd33);
    check("restart result", bus.result, 64'd6);
    watch_done(40, seen);
    check("restart single done", 64'(seen), 64'd0);
    last_exp = 64'd6;

    // Flush at cycle 15 of a MULT: idle next cycle, no done, result kept.
    bus.start = 1'b1; bus.op = 2'b00; bus.opA = 32'd4; bus.opB = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    watch_done(40, seen);
    check("flush no done", 64'(seen), 64'd0);
    check("flush result kept", bus.result, last_exp);

    // flush together with start in IDLE: start ignored.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.opA = 32'd9; bus.opB = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush+start busy", {63'd0, bus.busy}, 64'd0);
    watch_done(40, seen);
    check("flush+start no done", 64'(seen), 64'd0);

    // Reset in the middle of an operation.
    bus.start = 1'b1; bus.op = 2'b01; bus.opA = 32'hDEAD_BEEF; bus.opB = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midop reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    check("midop reset result", bus.result, 64'd0);
    watch_done(40, seen);
    check("midop reset no done", 64'(seen), 64'd0);

    // Random ops with biased corner operands.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d %h/%h", i, op, a, b), op, a, b, ref_model(op, a, b),
             ref_lat(op));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
